// File: rtl/stream_demux_pkg.sv
// Shared types and limits for the packet-level stream demultiplexer.
// Holds the FSM state encoding and the legal range for the output count.
package stream_demux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUTE = 2'd1,
      ST_DROP  = 2'd2
   } state_e;

   localparam int N_OUT_MIN = 2;
   localparam int N_OUT_MAX = 16;

   function automatic bit n_out_legal(input int n);
      return (n >= N_OUT_MIN) && (n <= N_OUT_MAX);
   endfunction

endpackage

// File: rtl/stream_slot.sv
// Single-entry valid/ready register stage holding one beat (payload + last).
// The writer may only write when the slot is empty or being drained this cycle.
module stream_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             wr_last_i,
   input  logic             rd_ready_i,
   output logic             rd_valid_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_last_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (wr_en_i) begin
         valid_d = 1'b1;
         data_d  = wr_data_i;
         last_d  = wr_last_i;
      end else if (valid_q && rd_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign rd_valid_o = valid_q;
   assign rd_data_o  = data_q;
   assign rd_last_o  = last_q;

endmodule

// File: rtl/stream_demux.sv
// Packet-level 1:N demultiplexer: steers whole packets from one valid/ready
// stream to one of N_OUT registered output slots, locking the select per packet.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | between packets; target follows in_sel on every beat
// ROUTE | multi-beat legal packet in flight; target locked to lock_q
// DROP  | multi-beat packet with illegal select; beats accepted, discarded
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int N_OUT = 2,
   localparam int SEL_W = $clog2(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_last,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic [N_OUT-1:0]       out_last,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic                   busy,
   output logic                   err_sel
);

   if (!n_out_legal(N_OUT)) begin : g_bad_n_out
      $error("stream_demux: N_OUT outside supported range");
   end

   state_e           state_q, state_d;
   logic [SEL_W-1:0] lock_q, lock_d;
   logic             err_q, err_d;
   logic [SEL_W-1:0] target;
   logic             sel_ok;
   logic             target_blocked;
   logic             ready_c;
   logic             accept;
   logic             wr_go;
   logic [SEL_W-1:0] wr_idx;

   assign sel_ok = (32'(in_sel) < N_OUT);
   assign target = (state_q == ST_ROUTE) ? lock_q : in_sel;

   // Only a full slot that is not draining this cycle holds off the input.
   always_comb begin
      target_blocked = 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
         if (target == SEL_W'(i)) target_blocked = out_valid[i] && !out_ready[i];
      end
   end

   always_comb begin
      ready_c = !target_blocked;
      if ((state_q == ST_DROP) || ((state_q == ST_IDLE) && !sel_ok)) ready_c = 1'b1;
      ready_c = ready_c && !rst;
   end

   assign in_ready = ready_c;
   assign accept   = in_valid && ready_c;

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      err_d   = err_q;
      wr_go   = 1'b0;
      wr_idx  = in_sel;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!sel_ok) begin
                  err_d = 1'b1;
                  if (!in_last) state_d = ST_DROP;
               end else begin
                  wr_go = 1'b1;
                  if (!in_last) begin
                     lock_d  = in_sel;
                     state_d = ST_ROUTE;
                  end
               end
            end
         end
         ST_ROUTE: begin
            wr_idx = lock_q;
            if (accept) begin
               wr_go = 1'b1;
               if (in_last) state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (accept && in_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

   for (genvar i = 0; i < N_OUT; i++) begin : g_slot
      stream_slot #(.WIDTH(WIDTH)) u_slot (
         .clk        (clk),
         .rst        (rst),
         .wr_en_i    (wr_go && (wr_idx == SEL_W'(i))),
         .wr_data_i  (in_data),
         .wr_last_i  (in_last),
         .rd_ready_i (out_ready[i]),
         .rd_valid_o (out_valid[i]),
         .rd_data_o  (out_data[i*WIDTH +: WIDTH]),
         .rd_last_o  (out_last[i])
      );
   end

   assign busy    = (state_q != ST_IDLE);
   assign err_sel = err_q;

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Packet-level 1:N demultiplexer, the distributing counterpart to the team's 2:1 gate-level selector.
- Takes one valid/ready input stream plus a select sideband and steers whole packets to one of N_OUT output streams.
- Select is sampled on the first beat and locked until the last beat.
- Each output has a single-entry register stage, so outputs are registered and independently back-pressurable.

Parameters:
- WIDTH, 8, data bits per beat.
- N_OUT, 2, number of output streams; legal range 2..16.
- SEL_W, $clog2(N_OUT), select width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  SEL_W  destination index; sampled only on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- out_data  output  N_OUT*WIDTH  payload of output i at slice [i*WIDTH +: WIDTH].
- out_last  output  N_OUT  per-output last flag.
- out_valid  output  N_OUT  per-output beat present.
- out_ready  input  N_OUT  per-output sink ready.
- busy  output  1  high while a multi-beat packet is locked (state ROUTE or DROP).
- err_sel  output  1  sticky; set when a packet arrives with in_sel >= N_OUT.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; out_valid, out_data, out_last, busy and err_sel all 0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-packet discards buffered beats and releases the lock; no partial-packet recovery.
- State machine, states IDLE / ROUTE / DROP:
  - IDLE: target = in_sel. On an accepted beat:
    - if in_sel >= N_OUT: set err_sel and discard the beat. If !in_last go to DROP, else stay IDLE.
    - else: write the beat to slot in_sel. If !in_last, latch lock_sel=in_sel and go to ROUTE; if in_last, stay IDLE (single-beat packet).
  - ROUTE: target = lock_sel; in_sel is ignored. An accepted beat is written to slot lock_sel. An accepted beat with in_last returns to IDLE.
  - DROP: in_ready=1 unconditionally; beats are discarded. An accepted beat with in_last returns to IDLE.
- in_ready (combinational, no in_valid dependency):
  - outside DROP, in_ready = !rst && (!out_valid[target] || out_ready[target]).
  - in IDLE with in_sel out of range, in_ready = !rst.
- Output slot i:
  - out_valid[i] is set on the cycle after a beat is written to it.
  - out_valid[i] clears after out_valid[i] && out_ready[i] unless a new beat is written in the same cycle; in that case it stays 1 with the new data (full throughput, 1 beat/cycle).
  - out_data and out_last hold stable while out_valid[i] && !out_ready[i].
- Latency: exactly 1 cycle from input accept to out_valid.
- Ordering: beats are never dropped, duplicated or reordered within a legal packet.
- Blocking: a stalled target blocks the input (head-of-line); non-target slots keep draining independently.
- busy = (state != IDLE).
- err_sel clears only on reset.

Decomposition:
- Package stream_demux_pkg holds the state enum (IDLE, ROUTE, DROP) and the N_OUT legality limits.
- Natural sub-module: stream_slot, a single-entry valid/ready register stage (WIDTH+1 bits), instantiated N_OUT times via generate.
- The top level holds only the FSM, the lock register and the ready/steering logic.

Test Plan:
- Reset then idle, in_valid=0 -> all out_valid=0, busy=0, err_sel=0; in_ready=1 once rst drops with slots empty.
- Single-beat packets, in_sel=0 then 1 (data 0xA5, 0x3C, in_last=1), out_ready all 1 -> 0xA5 on out 0 and 0x3C on out 1, each 1 cycle after accept; busy stays 0.
- 4-beat packet to out 1 (0x01..0x04) with in_sel toggled mid-packet -> all 4 beats on out 1, out_last only on 0x04, busy=1 for beats 1..3.
- Back-pressure: out_ready[1]=0 for 3 cycles mid-packet -> in_ready=0 while slot 1 is full; out_data[1] held stable; no beat lost; out 0 still drains a previously buffered beat.
- N_OUT=3, in_sel=3 on a 3-beat packet -> err_sel=1 sticky, DROP for 3 beats, no out_valid asserted; the following packet to out 2 is delivered normally.
- rst asserted mid-packet with out 0 full -> next cycle out_valid=0, state IDLE, busy=0; a new packet routes using a fresh in_sel.
